// File: rtl/defines.sv
// Shared core definitions: register-file address width and the
// hazard-controller FSM state type.
package defines;

  localparam int REG_FILE_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_MEMWAIT = 2'd1,
    HZ_ERR     = 2'd2
  } hzstate_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter: counts up by one per asserted increment and
// holds at its all-ones maximum instead of wrapping.
module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: step only when requested and not already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core: load-use
// bubbles, taken-branch flushes, and a pipeline freeze while data memory
// is busy, with a timeout that parks the core in a sticky error state.
module hazard_ctrl
  import defines::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
  input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
  input  logic                         id_two_src,
  input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
  input  logic                         exe_mem_r_en,
  input  logic                         exe_wb_en,
  input  logic                         br_taken,
  input  logic                         mem_req,
  input  logic                         mem_ready,
  output logic                         pc_en,
  output logic                         ifid_en,
  output logic                         idexe_en,
  output logic                         exemem_en,
  output logic                         ifid_flush,
  output logic                         idexe_flush,
  output logic                         memwb_flush,
  output logic                         mem_err,
  output hzstate_t                     state,
  output logic [CNT_W-1:0]             lu_cnt,
  output logic [CNT_W-1:0]             br_cnt,
  output logic [CNT_W-1:0]             mw_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hzstate_t          state_q;
  hzstate_t          state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  logic freeze;
  logic lu;
  logic lu_inc;
  logic br_inc;
  logic mw_inc;

  // The pipeline freezes on any outstanding, unfinished memory access, and
  // permanently once the memory has timed out.
  assign freeze = ((state_q == HZ_RUN)     && mem_req && !mem_ready) ||
                  ((state_q == HZ_MEMWAIT) && !mem_ready)            ||
                   (state_q == HZ_ERR);

  // Load-use: the EXE load writes a non-zero register that ID reads now.
  assign lu = id_valid && exe_mem_r_en && exe_wb_en && (exe_dest != '0) &&
              ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));

  // Memory-wait FSM and its wait counter. The request cycle is wait 1, so
  // the error fires after MEM_TIMEOUT+1 consecutive not-ready cycles.
  // NOTE: every combinationally assigned signal gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      HZ_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = HZ_MEMWAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      HZ_MEMWAIT: begin
        if (mem_ready) begin
          state_d = HZ_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
          state_d = HZ_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      HZ_ERR: begin
        state_d = HZ_ERR;
      end
      default: begin
        state_d = HZ_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  // NOTE: reset is asynchronous and active-high, so a reset asserted
  // mid-wait or in the error state takes effect without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Output mux, priority freeze > branch > load-use > normal. All strobes
  // stay low while reset is held. A frozen cycle bubbles MEM/WB so the
  // stalled MEM instruction is not written back twice.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idexe_en    = 1'b0;
    exemem_en   = 1'b0;
    ifid_flush  = 1'b0;
    idexe_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      if (freeze) begin
        memwb_flush = 1'b1;
      end else if (br_taken) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idexe_en    = 1'b1;
        exemem_en   = 1'b1;
        ifid_flush  = 1'b1;
        idexe_flush = 1'b1;
      end else if (lu) begin
        idexe_en    = 1'b1;
        idexe_flush = 1'b1;
        exemem_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idexe_en  = 1'b1;
        exemem_en = 1'b1;
      end
    end
  end

  // A branch held through a freeze is counted once, in the release cycle.
  assign br_inc = !freeze && br_taken;
  assign lu_inc = !freeze && !br_taken && lu;
  assign mw_inc = freeze && (state_q != HZ_ERR);

  hz_sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (lu_inc),
    .cnt_o (lu_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (br_inc),
    .cnt_o (br_cnt)
  );

  hz_sat_counter #(.W(CNT_W)) u_mw_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (mw_inc),
    .cnt_o (mw_cnt)
  );

  assign mem_err = (state_q == HZ_ERR);
  assign state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a behavioural model checked every
// cycle on the falling edge, plus directed scenarios with literal values.
module tb_hazard_ctrl;
  import defines::*;

  localparam int TIMEOUT = 4;
  localparam int CW      = 2;
  localparam int CMAX    = (1 << CW) - 1;
  localparam int AW      = REG_FILE_ADDR_LEN;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_two_src, exe_mem_r_en, exe_wb_en;
  logic [AW-1:0] id_src1, id_src2, exe_dest;
  logic          br_taken, mem_req, mem_ready;
  logic          pc_en, ifid_en, idexe_en, exemem_en;
  logic          ifid_flush, idexe_flush, memwb_flush, mem_err;
  hzstate_t      dut_state;
  logic [CW-1:0] lu_cnt, br_cnt, mw_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_wb_en    (exe_wb_en),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idexe_en     (idexe_en),
    .exemem_en    (exemem_en),
    .ifid_flush   (ifid_flush),
    .idexe_flush  (idexe_flush),
    .memwb_flush  (memwb_flush),
    .mem_err      (mem_err),
    .state        (dut_state),
    .lu_cnt       (lu_cnt),
    .br_cnt       (br_cnt),
    .mw_cnt       (mw_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_nr: not-ready cycles seen in the current access, request cycle included.
  int m_wait, m_err, m_nr, m_lu, m_br, m_mw;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic bit m_freeze();
    if (m_err != 0) return 1'b1;
    if (mem_ready) return 1'b0;
    return (m_wait != 0) || mem_req;
  endfunction

  function automatic bit m_loaduse();
    if (!(id_valid && exe_mem_r_en && exe_wb_en)) return 1'b0;
    if (exe_dest == 0) return 1'b0;
    return (exe_dest == id_src1) || (id_two_src && exe_dest == id_src2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 0; m_err <= 0; m_nr <= 0;
      m_lu <= 0; m_br <= 0; m_mw <= 0;
    end else if (m_err == 0) begin
      if (m_freeze()) begin
        m_mw <= sat(m_mw);
        m_nr <= m_nr + 1;
        if (m_nr + 1 > TIMEOUT) m_err <= 1;
        else m_wait <= 1;
      end else begin
        m_wait <= 0;
        m_nr   <= 0;
        if (br_taken) m_br <= sat(m_br);
        else if (m_loaduse()) m_lu <= sat(m_lu);
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic [6:0] exp_v; // {pc, ifid, idexe, exemem, ifid_fl, idexe_fl, memwb_fl}
    int exp_st;
    if (rst)                 exp_v = 7'b0000_000;
    else if (m_freeze())     exp_v = 7'b0000_001;
    else if (br_taken)       exp_v = 7'b1111_110;
    else if (m_loaduse())    exp_v = 7'b0011_010;
    else                     exp_v = 7'b1111_000;
    exp_st = (m_err != 0) ? 2 : ((m_wait != 0) ? 1 : 0);
    check("pc_en",       32'(pc_en),       32'(exp_v[6]));
    check("ifid_en",     32'(ifid_en),     32'(exp_v[5]));
    check("idexe_en",    32'(idexe_en),    32'(exp_v[4]));
    check("exemem_en",   32'(exemem_en),   32'(exp_v[3]));
    check("ifid_flush",  32'(ifid_flush),  32'(exp_v[2]));
    check("idexe_flush", 32'(idexe_flush), 32'(exp_v[1]));
    check("memwb_flush", 32'(memwb_flush), 32'(exp_v[0]));
    check("state",       32'(dut_state),   32'(exp_st));
    check("mem_err",     32'(mem_err),     32'(m_err));
    check("lu_cnt",      32'(lu_cnt),      32'(m_lu));
    check("br_cnt",      32'(br_cnt),      32'(m_br));
    check("mw_cnt",      32'(mw_cnt),      32'(m_mw));
  end

  // ---------------- directed stimulus ----------------
  task automatic clear_inputs();
    id_valid = 0; id_two_src = 0; exe_mem_r_en = 0; exe_wb_en = 0;
    id_src1 = '0; id_src2 = '0; exe_dest = '0;
    br_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu(input logic [AW-1:0] d, input logic [AW-1:0] s1);
    id_valid = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = d; id_src1 = s1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    #3;
    check("rst pc_en",   32'(pc_en),     32'd0);
    check("rst state",   32'(dut_state), 32'(HZ_RUN));
    check("rst lu_cnt",  32'(lu_cnt),    32'd0);
    check("rst mem_err", 32'(mem_err),   32'd0);
    step(); step();
    rst = 0;
    #1;
    check("normal pc_en", 32'(pc_en), 32'd1);

    // Load-use on src1
    set_lu(5'd5, 5'd5);
    #1;
    check("lu pc_en",       32'(pc_en),       32'd0);
    check("lu ifid_en",     32'(ifid_en),     32'd0);
    check("lu idexe_flush", 32'(idexe_flush), 32'd1);
    step();
    clear_inputs();
    #1;
    check("lu_cnt after lu", 32'(lu_cnt), 32'd1);
    // exe_dest = 0 never stalls
    set_lu(5'd0, 5'd0);
    #1;
    check("x0 pc_en", 32'(pc_en), 32'd1);
    step();
    // Second-source hazard, with and without id_two_src
    clear_inputs();
    set_lu(5'd7, 5'd3);
    id_src2 = 5'd7; id_two_src = 1;
    #1;
    check("src2 pc_en", 32'(pc_en), 32'd0);
    id_two_src = 0;
    #1;
    check("src2 unused pc_en", 32'(pc_en), 32'd1);
    step();

    // Branch beats load-use
    do_reset();
    set_lu(5'd5, 5'd5);
    br_taken = 1;
    #1;
    check("br pc_en",       32'(pc_en),       32'd1);
    check("br ifid_flush",  32'(ifid_flush),  32'd1);
    check("br idexe_flush", 32'(idexe_flush), 32'd1);
    step();
    clear_inputs();
    #1;
    check("br br_cnt", 32'(br_cnt), 32'd1);
    check("br lu_cnt", 32'(lu_cnt), 32'd0);

    // Zero-wait access: no freeze, no state change
    mem_req = 1; mem_ready = 1;
    #1;
    check("zw pc_en", 32'(pc_en), 32'd1);
    step();
    #1;
    check("zw state", 32'(dut_state), 32'(HZ_RUN));

    // Memory wait: 3 not-ready cycles then release
    do_reset();
    mem_req = 1; mem_ready = 0;
    #1;
    check("mw pc_en",       32'(pc_en),       32'd0);
    check("mw memwb_flush", 32'(memwb_flush), 32'd1);
    step(); step();
    check("mw state", 32'(dut_state), 32'(HZ_MEMWAIT));
    step();
    mem_ready = 1;
    #1;
    check("mw release pc_en",       32'(pc_en),       32'd1);
    check("mw release memwb_flush", 32'(memwb_flush), 32'd0);
    step();
    clear_inputs();
    #1;
    check("mw mw_cnt",     32'(mw_cnt),    32'd3);
    check("mw state back", 32'(dut_state), 32'(HZ_RUN));

    // Branch held through a freeze: flushed and counted once on release
    do_reset();
    mem_req = 1; mem_ready = 0; br_taken = 1;
    #1;
    check("bf frozen ifid_flush", 32'(ifid_flush), 32'd0);
    step(); step();
    mem_ready = 1;
    #1;
    check("bf release ifid_flush",  32'(ifid_flush),  32'd1);
    check("bf release idexe_flush", 32'(idexe_flush), 32'd1);
    step();
    clear_inputs();
    #1;
    check("bf br_cnt", 32'(br_cnt), 32'd1);

    // Counter saturation: 5 load-use events on a 2-bit counter
    do_reset();
    set_lu(5'd9, 5'd9);
    repeat (5) step();
    clear_inputs();
    #1;
    check("sat lu_cnt", 32'(lu_cnt), 32'd3);

    // Ready in the last allowed cycle (5th) releases without error
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (TIMEOUT) step();
    mem_ready = 1;
    #1;
    check("last-cycle pc_en", 32'(pc_en), 32'd1);
    step();
    clear_inputs();
    #1;
    check("last-cycle mem_err", 32'(mem_err), 32'd0);
    check("last-cycle state",   32'(dut_state), 32'(HZ_RUN));

    // Timeout: error after the 5th not-ready cycle, sticky, cleared by rst
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (TIMEOUT) step();
    #1;
    check("to before mem_err", 32'(mem_err), 32'd0);
    step();
    check("to mem_err", 32'(mem_err),   32'd1);
    check("to state",   32'(dut_state), 32'(HZ_ERR));
    mem_ready = 1;
    #1;
    check("to frozen pc_en",       32'(pc_en),       32'd0);
    check("to frozen memwb_flush", 32'(memwb_flush), 32'd1);
    step(); step();
    check("to sticky mem_err", 32'(mem_err), 32'd1);
    check("to mw_cnt",         32'(mw_cnt),  32'd3);
    rst = 1;
    #1;
    check("to rst mem_err", 32'(mem_err),   32'd0);
    check("to rst state",   32'(dut_state), 32'(HZ_RUN));

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    mem_req = 1; mem_ready = 0;
    step(); step();
    check("ar mw_cnt before", 32'(mw_cnt), 32'd2);
    rst = 1;
    #1;
    check("ar state",  32'(dut_state), 32'(HZ_RUN));
    check("ar mw_cnt", 32'(mw_cnt),    32'd0);
    check("ar pc_en",  32'(pc_en),     32'd0);
    clear_inputs();
    step();
    rst = 0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. Sequences the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers: inserts load-use bubbles into ID/EXE, flushes wrong-path instructions on a taken branch, and freezes the pipeline while a variable-latency data memory is busy. A memory-wait FSM with a timeout drives the freeze. Saturating event counters record stall and flush activity.

## Interface
- REG_FILE_ADDR_LEN, 5, register-address width (from `defines`)
- MEM_TIMEOUT, 64, consecutive not-ready cycles before a memory error is declared (≥2)
- CNT_W, 16, width of each performance counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_src1, id_src2  in  REG_FILE_ADDR_LEN  ID-stage source registers
- id_two_src  in  1  ID instruction reads id_src2
- exe_dest  in  REG_FILE_ADDR_LEN  destination of the instruction in EXE (ID/EXE output)
- exe_mem_r_en, exe_wb_en  in  1  EXE instruction is a load / writes back
- br_taken  in  1  branch resolved taken in EXE
- mem_req  in  1  MEM stage is accessing data memory (read or write)
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idexe_en, exemem_en  out  1  load enables; 0 holds the register
- ifid_flush, idexe_flush, memwb_flush  out  1  the register loads a bubble (all control bits zero)
- mem_err  out  1  sticky memory-timeout error
- state  out  2  current FSM state (hzstate_t)
- lu_cnt, br_cnt, mw_cnt  out  CNT_W  load-use bubbles, branch flushes, memory-wait cycles

## Operation
- FSM states: HZ_RUN, HZ_MEMWAIT, HZ_ERR.
- freeze = (state==HZ_RUN && mem_req && !mem_ready) || (state==HZ_MEMWAIT && !mem_ready) || state==HZ_ERR.
- Freeze drives pc_en, ifid_en, idexe_en and exemem_en to 0, ifid_flush and idexe_flush to 0, and memwb_flush to 1. This prevents a double write-back.
- lu = id_valid && exe_mem_r_en && exe_wb_en && exe_dest!=0 && (exe_dest==id_src1 || (id_two_src && exe_dest==id_src2)).
- Priority: freeze > branch > load-use > normal.
- Branch (not frozen, br_taken=1): all enables are 1, ifid_flush=1, idexe_flush=1, memwb_flush=0. br_cnt increments.
- Load-use (not frozen, no branch, lu=1): pc_en=0, ifid_en=0, idexe_en=1, idexe_flush=1, exemem_en=1. lu_cnt increments.
- Normal: all enables are 1 and all flushes are 0.
- Transitions:
  - HZ_RUN→HZ_MEMWAIT on mem_req && !mem_ready.
  - HZ_MEMWAIT→HZ_RUN on mem_ready. The release is combinational in that same cycle, so the enables are high.
  - HZ_MEMWAIT→HZ_ERR once the wait counter reaches MEM_TIMEOUT with mem_ready still 0.
  - HZ_ERR is absorbing until rst.
- Wait counter: loads 1 on entry to HZ_MEMWAIT and increments each HZ_MEMWAIT cycle with mem_ready=0.
- mw_cnt counts every frozen cycle in HZ_RUN or HZ_MEMWAIT. Frozen cycles in HZ_ERR are not counted.
- mem_err=1 iff state==HZ_ERR.
- All counters saturate at 2^CNT_W−1 and never wrap.
- A branch held during a freeze keeps br_taken asserted, because EXE is frozen. The flush is applied, and counted once, in the release cycle.

## Timing
- All enables and flushes are combinational from the current state and inputs (zero latency). State, wait counter and perf counters are registered.
- While rst=1: state=HZ_RUN, the wait counter and all perf counters are 0, mem_err=0, all enables are 0 and all flushes are 0.
- Reset asserted mid-wait or in HZ_ERR returns to HZ_RUN asynchronously.
- First cycle after rst deasserts: normal operation.
- A zero-wait access (mem_req && mem_ready in HZ_RUN) causes no freeze and no state change.
- Boundary cases:
  - With MEM_TIMEOUT=N and mem_ready held at 0, mem_err rises on the clock edge after the (N+1)-th not-ready cycle, counting from the request cycle.
  - mem_ready arriving in the final allowed cycle releases normally; no error.

## Structure
- `hzstate_t` (2-bit enum: HZ_RUN, HZ_MEMWAIT, HZ_ERR) goes in the shared `defines` package alongside REG_FILE_ADDR_LEN.
- Sub-module `hz_sat_counter`: a parameterised-width saturating counter with increment input and async reset. It is instantiated for lu_cnt, br_cnt and mw_cnt.
- The FSM, the hazard decode and the output mux stay in hazard_ctrl.

## Test plan
- Load-use: exe_dest=5, exe_mem_r_en=1, exe_wb_en=1, id_src1=5, id_valid=1 → that cycle pc_en=0, ifid_en=0, idexe_flush=1; lu_cnt=1. With exe_dest=0 and the same inputs → no stall.
- Branch beats load-use: br_taken=1 and lu conditions true → pc_en=1, ifid_flush=1, idexe_flush=1; br_cnt=1, lu_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → all enables 0 and memwb_flush=1 for 3 cycles; state HZ_MEMWAIT; release in cycle 4; mw_cnt=3; state back to HZ_RUN.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 → mem_err=1 after the 5th not-ready cycle and stays 1 after mem_ready rises; freeze persists; rst clears it.
- Branch during freeze: br_taken=1 while in HZ_MEMWAIT → no flush until the mem_ready cycle, then one flush; br_cnt=1.
- Saturation and reset: CNT_W=2, force 5 load-use events → lu_cnt=3. Assert rst mid-HZ_MEMWAIT → state HZ_RUN and counters 0 immediately, without waiting for a clock edge.
